// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester front end for a word-addressed data memory. Requester 0
//   (load/store unit) and requester 1 (loader/debug) share the memory through
//   round-robin arbitration. Byte/half/word accesses arrive byte-addressed.
//   Loads are served with one word read followed by lane extraction and
//   sign/zero extension. Word stores need one word write. Sub-word stores need
//   a read-modify-write pair because the memory only writes whole words.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   rN_valid/rN_ready   request handshake (N = 0, 1)
//   rN_write            1 = store, 0 = load
//   rN_addr             byte address
//   rN_size             00 byte, 01 half, 10 word, 11 illegal
//   rN_unsigned         load extension: 1 = zero, 0 = sign
//   rN_wdata            right-aligned store data
//   rN_rvalid           one-cycle response pulse
//   rN_rdata, rN_rerr   response data / error flag, zero outside rvalid
//   mem_read/mem_write  memory strobes (never both high)
//   mem_addr            word index (byte address >> 2)
//   mem_wdata           full word to write
//   mem_rdata           combinational read data from memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester 0
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_write,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [1:0]            r0_size,
  input  logic                  r0_unsigned,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_rerr,
  // requester 1
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_write,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [1:0]            r1_size,
  input  logic                  r1_unsigned,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_rerr,
  // memory
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    id_q, id_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rerr_q, rerr_d;

  // Selected incoming request
  logic                    grant_id;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [1:0]              req_size;
  logic                    req_uns;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    req_illegal;

  // Extract the addressed lane from a memory word and extend it to full width.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half lane of a word with right-aligned data.
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [1:0]            size,
    input logic [DATA_WIDTH-1:0] wd
  );
    logic [DATA_WIDTH-1:0] r;
    r = word;
    if (size == 2'b00) begin
      r[8*lane +: 8] = wd[7:0];
    end else begin
      r[16*lane[1] +: 16] = wd[15:0];
    end
    return r;
  endfunction

  // When both requesters are valid the one not served last wins; otherwise
  // the sole valid requester wins.
  assign grant_id  = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
  assign req_write = grant_id ? r1_write    : r0_write;
  assign req_addr  = grant_id ? r1_addr     : r0_addr;
  assign req_size  = grant_id ? r1_size     : r0_size;
  assign req_uns   = grant_id ? r1_unsigned : r0_unsigned;
  assign req_wdata = grant_id ? r1_wdata    : r0_wdata;

  assign req_illegal = (req_size == 2'b11) ||
                       ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    rdata_d      = rdata_q;
    rerr_d       = rerr_q;

    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    r0_rvalid = 1'b0;
    r1_rvalid = 1'b0;
    r0_rdata  = '0;
    r1_rdata  = '0;
    r0_rerr   = 1'b0;
    r1_rerr   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        // Ready is suppressed while reset is held so nothing looks accepted.
        if (!reset && (r0_valid || r1_valid)) begin
          r0_ready     = ~grant_id;
          r1_ready     = grant_id;
          last_grant_d = grant_id;
          id_d         = grant_id;
          write_d      = req_write;
          addr_d       = req_addr;
          size_d       = req_size;
          uns_d        = req_uns;
          wdata_d      = req_wdata;
          rdata_d      = '0;
          rerr_d       = req_illegal;
          if (req_illegal) begin
            state_d = S_RESP;
          end else if (!req_write) begin
            state_d = S_RD;
          end else if (req_size == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        mem_read = 1'b1;
        mem_addr = addr_q[ADDR_WIDTH-1:2];
        rdata_d  = load_extract(mem_rdata, addr_q[1:0], size_q, uns_q);
        state_d  = S_RESP;
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_q[ADDR_WIDTH-1:2];
        mem_wdata = wdata_q;
        state_d   = S_RESP;
      end
      S_RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = addr_q[ADDR_WIDTH-1:2];
        word_d   = mem_rdata;
        state_d  = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_q[ADDR_WIDTH-1:2];
        mem_wdata = store_merge(word_q, addr_q[1:0], size_q, wdata_q);
        state_d   = S_RESP;
      end
      S_RESP: begin
        // rdata_q is zero for stores and errors, so it can be forwarded as is.
        r0_rvalid = ~id_q;
        r1_rvalid = id_q;
        r0_rdata  = id_q ? '0 : rdata_q;
        r1_rdata  = id_q ? rdata_q : '0;
        r0_rerr   = ~id_q & rerr_q;
        r1_rerr   = id_q & rerr_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;  // requester 0 wins the first contended grant
      id_q         <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      word_q       <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      rdata_q      <= rdata_d;
      rerr_q       <= rerr_d;
    end
  end

  // write_q is latched for completeness of the request record; the access
  // path is already fully encoded in the state sequence.
  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port controller in front of the word-addressed data memory.
- Shares the memory between requester 0 (CPU load/store unit) and requester 1 (loader/debug port) using round-robin arbitration.
- Converts byte-addressed byte/half/word loads and stores into word accesses: lane extraction plus sign/zero extension on loads, read-modify-write sequencing for sub-word stores (the memory has only a full-word write).

Parameters:
ADDR_WIDTH, 32, byte-address width of requester ports; memory word index is ADDR_WIDTH-2 bits.
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes). Other values are unsupported.

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
rN_valid  in  1  request valid (N = 0, 1, one set per requester)
rN_ready  out  1  request accepted this cycle when valid & ready
rN_write  in  1  1 = store, 0 = load
rN_addr  in  ADDR_WIDTH  byte address
rN_size  in  2  00 byte, 01 half, 10 word, 11 illegal
rN_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
rN_wdata  in  DATA_WIDTH  store data, right-aligned
rN_rvalid  out  1  one-cycle response pulse
rN_rdata  out  DATA_WIDTH  load result; 0 for stores and errors
rN_rerr  out  1  valid with rvalid; misaligned or illegal size
mem_read  out  1  to memory
mem_write  out  1  to memory; memory commits at posedge
mem_addr  out  ADDR_WIDTH-2  word index = byte addr >> 2
mem_wdata  out  DATA_WIDTH  full word to write
mem_rdata  in  DATA_WIDTH  combinational read data from memory

Behaviour:
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- Reset (async, immediate):
  - state = IDLE, last_grant = 1 (requester 0 wins first).
  - All rN_ready, rN_rvalid, rN_rerr, mem_read, mem_write = 0; rdata, mem_addr, mem_wdata = 0.
  - An in-flight request is dropped with no response; no write is committed unless its posedge already occurred before reset rose.
- Arbitration (IDLE only):
  - ready is combinational: winner = sole valid requester; if both valid, the one not equal to last_grant.
  - Accept on valid & ready at edge N: latch write/addr/size/unsigned/wdata/id; last_grant = id.
  - ready = 0 in every non-IDLE state. A request is never accepted in the same cycle its predecessor's rvalid is high.
- Error check at accept:
  - Illegal: size 11; half with addr[0] = 1; word with addr[1:0] != 0.
  - Go to RESP; rerr = 1, rdata = 0, no mem strobe. rvalid at cycle N+1.
- Load: RD (cycle N+1).
  - mem_read = 1; capture mem_rdata at the edge.
  - Byte k = addr[1:0] → bits [8k+7:8k]; half → addr[1] selects [15:0] or [31:16].
  - Extend per unsigned.
  - RESP at N+2: rvalid = 1, rdata = result.
- Word store: WR (N+1), mem_write = 1, mem_wdata = wdata; RESP at N+2.
- Sub-word store:
  - RMW_RD (N+1): mem_read = 1; capture word.
  - RMW_WR (N+2): mem_write = 1; mem_wdata = captured word with the addressed byte/half lane replaced by wdata[7:0] / wdata[15:0].
  - RESP at N+3.
- mem_addr is held constant from the first access state through RMW_WR. mem_read and mem_write are never both 1.
- RESP:
  - Exactly one rN_rvalid pulses, for the latched id only.
  - rdata/rerr are meaningful only while rvalid = 1 and are 0 otherwise.
  - Then return to IDLE.
- Little-endian lanes; address wrap at 2^ADDR_WIDTH is natural truncation.

Test Plan:
- Word store 0xDEADBEEF to 0x101C by r0, then word load → mem_addr 0x407, store rvalid at N+2, load rvalid at N+2 with rdata 0xDEADBEEF, rerr 0.
- Byte store 0xA5 to 0x101D over 0xDEADBEEF → mem_write only in cycle N+2, word becomes 0xDEADA5EF.
  - Follow-up loads: byte signed 0x101D → 0xFFFFFFA5; byte unsigned → 0x000000A5; half signed 0x101E → 0xFFFFDEAD.
- r0 and r1 both hold valid continuously after reset → grants r0, r1, r0, r1. Each rvalid appears only on the granted port; no grant while busy.
- Misaligned requests: word load 0x1002, half store 0x1001, and size 11 → rerr = 1 at N+1, rdata 0, mem_read/mem_write never asserted, memory unchanged.
- Reset raised during RMW_RD of a byte store → outputs drop to 0 immediately, mem_write never asserted, word unchanged, first post-reset grant goes to r0.
- Half store 0x1234 to 0x1FFE with r1 only valid → r1 granted, upper half of word 0x7FF replaced, lower half preserved.
